// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
//   ALU operand forwarding selects (combinational) and load-use stall
//   sequencing (registered IDLE/STALL machine, LOAD_STALL bubbles per hazard).
//   Optional macro HAZ_STALL_CNT_EN adds a saturating bubble counter on
//   output stall_count.
module hazard_forward_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_STALL = 1,   // bubbles per load-use hazard, 1..3
    parameter int CNT_W      = 32   // stall_count width (optional feature)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] idex_rs1,
    input  logic [REG_ADDR_W-1:0] idex_rs2,
    input  logic [REG_ADDR_W-1:0] idex_rd,
    input  logic                  idex_memread,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic                  exmem_regwrite,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic                  memwb_regwrite,
    input  logic [REG_ADDR_W-1:0] ifid_rs1,
    input  logic [REG_ADDR_W-1:0] ifid_rs2,
    input  logic                  ifid_valid,
    input  logic                  flush,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  idex_bubble,
    output logic                  stall_busy
`ifdef HAZ_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_count
`endif
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_STALL = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_nxt;
    logic       w_det;
    logic       w_stall;

    // Reject configurations the 2-bit down-counter cannot sequence.
    if (LOAD_STALL < 1 || LOAD_STALL > 3 || CNT_W < 1) begin : g_bad_param
        $error("hazard_forward_unit: LOAD_STALL must be 1..3 and CNT_W >= 1");
    end

    // Forwarding selects: EX/MEM beats MEM/WB, x0 never forwards, quiet in reset.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (rst) begin
            if (exmem_regwrite && exmem_rd != '0 && exmem_rd == idex_rs1)
                fwd_a = 2'b01;
            else if (memwb_regwrite && memwb_rd != '0 && memwb_rd == idex_rs1)
                fwd_a = 2'b10;

            if (exmem_regwrite && exmem_rd != '0 && exmem_rd == idex_rs2)
                fwd_b = 2'b01;
            else if (memwb_regwrite && memwb_rd != '0 && memwb_rd == idex_rs2)
                fwd_b = 2'b10;
        end
    end

    // Load in EX feeding an operand of a real ID instruction; a redirect kills it.
    assign w_det = idex_memread && (idex_rd != '0) && ifid_valid &&
                   ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2)) && !flush;

    // State register: synchronous active-low reset abandons any stall in progress.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: the detect cycle is bubble 1, STALL covers the remaining ones.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_det && LOAD_STALL > 1) begin
                    w_state_nxt = S_STALL;
                    w_cnt_nxt   = 2'(LOAD_STALL - 1);
                end
            end
            S_STALL: begin
                if (flush || r_cnt == 2'd1) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 2'd0;
                end else begin
                    w_cnt_nxt   = r_cnt - 2'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 2'd0;
            end
        endcase
    end

    // Stall outputs: flush always wins, reset forces normal flow.
    always_comb begin
        w_stall     = rst && (((r_state == S_IDLE) && w_det) ||
                              ((r_state == S_STALL) && !flush));
        pc_write    = !w_stall;
        ifid_write  = !w_stall;
        idex_bubble = w_stall;
        stall_busy  = (r_state == S_STALL);
    end

`ifdef HAZ_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_count;

    // Saturating count of issued bubbles.
    always_ff @(posedge clk) begin
        if (!rst)
            r_stall_count <= '0;
        else if (idex_bubble && r_stall_count != '1)
            r_stall_count <= r_stall_count + CNT_W'(1);
    end

    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit
//   Three instances (LOAD_STALL = 1, 2, 3; CNT_W = 4) share one stimulus
//   stream. A cycle-level model tracks "bubbles still owed" per instance and
//   is compared against every instance on each falling edge. Directed
//   literal checks pin the model; random traffic follows. Builds with or
//   without HAZ_STALL_CNT_EN.
module tb_hazard_forward_unit;

    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] idex_rs1, idex_rs2, idex_rd;
    logic          idex_memread;
    logic [AW-1:0] exmem_rd;
    logic          exmem_regwrite;
    logic [AW-1:0] memwb_rd;
    logic          memwb_regwrite;
    logic [AW-1:0] ifid_rs1, ifid_rs2;
    logic          ifid_valid;
    logic          flush;

    logic [1:0]    fa [3];
    logic [1:0]    fb [3];
    logic          pw [3];
    logic          iw [3];
    logic          bub [3];
    logic          busy [3];
    logic [CW-1:0] sc [3];

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk_on    = 1'b0;

    // Model state: bubbles still owed after the current cycle, and bubble count.
    int ls_val [3] = '{1, 2, 3};
    int rem    [3] = '{0, 0, 0};
    int cnt_m  [3] = '{0, 0, 0};

    initial forever #5 clk = ~clk;

    hazard_forward_unit #(.REG_ADDR_W(AW), .LOAD_STALL(1), .CNT_W(CW)) u_ls1 (
        .clk(clk), .rst(rst),
        .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
        .idex_memread(idex_memread),
        .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
        .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_valid(ifid_valid),
        .flush(flush),
        .fwd_a(fa[0]), .fwd_b(fb[0]), .pc_write(pw[0]), .ifid_write(iw[0]),
        .idex_bubble(bub[0]), .stall_busy(busy[0])
`ifdef HAZ_STALL_CNT_EN
        , .stall_count(sc[0])
`endif
    );

    hazard_forward_unit #(.REG_ADDR_W(AW), .LOAD_STALL(2), .CNT_W(CW)) u_ls2 (
        .clk(clk), .rst(rst),
        .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
        .idex_memread(idex_memread),
        .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
        .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_valid(ifid_valid),
        .flush(flush),
        .fwd_a(fa[1]), .fwd_b(fb[1]), .pc_write(pw[1]), .ifid_write(iw[1]),
        .idex_bubble(bub[1]), .stall_busy(busy[1])
`ifdef HAZ_STALL_CNT_EN
        , .stall_count(sc[1])
`endif
    );

    hazard_forward_unit #(.REG_ADDR_W(AW), .LOAD_STALL(3), .CNT_W(CW)) u_ls3 (
        .clk(clk), .rst(rst),
        .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
        .idex_memread(idex_memread),
        .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
        .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_valid(ifid_valid),
        .flush(flush),
        .fwd_a(fa[2]), .fwd_b(fb[2]), .pc_write(pw[2]), .ifid_write(iw[2]),
        .idex_bubble(bub[2]), .stall_busy(busy[2])
`ifdef HAZ_STALL_CNT_EN
        , .stall_count(sc[2])
`endif
    );

`ifndef HAZ_STALL_CNT_EN
    initial for (int k = 0; k < 3; k++) sc[k] = '0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [1:0] model_fwd(input logic [AW-1:0] rs);
        if (!rst) return 2'b00;
        if (exmem_regwrite && exmem_rd != 0 && exmem_rd == rs) return 2'b01;
        if (memwb_regwrite && memwb_rd != 0 && memwb_rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic model_det();
        return idex_memread && idex_rd != 0 && ifid_valid &&
               (idex_rd == ifid_rs1 || idex_rd == ifid_rs2) && !flush;
    endfunction

    // A new hazard only starts when nothing is owed; owed bubbles need !flush.
    function automatic logic model_stall(input int k);
        if (!rst) return 1'b0;
        if (rem[k] == 0) return model_det();
        return !flush;
    endfunction

    function automatic logic [7:0] model_outs(input int k);
        logic s;
        s = model_stall(k);
        return {model_fwd(idex_rs1), model_fwd(idex_rs2), !s, !s, s, (rem[k] > 0)};
    endfunction

    // Advance the model on each rising edge.
    always @(posedge clk) begin
        if (!rst) chk_on <= 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (!rst) begin
                rem[k]   <= 0;
                cnt_m[k] <= 0;
            end else begin
                if (model_stall(k) && cnt_m[k] < (1 << CW) - 1) cnt_m[k] <= cnt_m[k] + 1;
                if (rem[k] > 0)       rem[k] <= flush ? 0 : rem[k] - 1;
                else if (model_det()) rem[k] <= ls_val[k] - 1;
            end
        end
    end

    // Compare every instance against the model mid-cycle.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("ls%0d_outs", k + 1),
                      {24'd0, fa[k], fb[k], pw[k], iw[k], bub[k], busy[k]},
                      {24'd0, model_outs(k)});
`ifdef HAZ_STALL_CNT_EN
                check($sformatf("ls%0d_count", k + 1), {28'd0, sc[k]}, 32'(cnt_m[k]));
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        idex_rs1 = '0; idex_rs2 = '0; idex_rd = '0; idex_memread = 1'b0;
        exmem_rd = '0; exmem_regwrite = 1'b0;
        memwb_rd = '0; memwb_regwrite = 1'b0;
        ifid_rs1 = '0; ifid_rs2 = '0; ifid_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic hazard();
        idex_memread = 1'b1; idex_rd = 5'd7; ifid_rs2 = 5'd7; ifid_valid = 1'b1;
    endtask

    initial begin
        quiet();
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // Forwarding priority.
        idex_rs1 = 5'd5; exmem_rd = 5'd5; exmem_regwrite = 1'b1;
        memwb_rd = 5'd5; memwb_regwrite = 1'b1;
        #1 check("fwd_prio_exmem", 32'(fa[0]), 32'h1);
        exmem_regwrite = 1'b0;
        #1 check("fwd_prio_memwb", 32'(fa[0]), 32'h2);
        memwb_regwrite = 1'b0;
        #1 check("fwd_prio_none", 32'(fa[0]), 32'h0);

        // x0 guard.
        tick();
        quiet();
        idex_rs2 = 5'd0; exmem_rd = 5'd0; exmem_regwrite = 1'b1;
        idex_rd = 5'd0; idex_memread = 1'b1; ifid_rs1 = 5'd0; ifid_valid = 1'b1;
        #1 check("x0_fwd_b", 32'(fb[0]), 32'h0);
        check("x0_no_stall", 32'(pw[2]), 32'h1);

        // Load-use: one bubble for LS=1, three for LS=3.
        tick();
        quiet();
        hazard();
        #1 check("lu_c1_ls1", {28'd0, pw[0], iw[0], bub[0], busy[0]}, 32'b0010);
        check("lu_c1_ls3", {28'd0, pw[2], iw[2], bub[2], busy[2]}, 32'b0010);
        tick();
        idex_memread = 1'b0;
        #1 check("lu_c2_ls1", {28'd0, pw[0], iw[0], bub[0], busy[0]}, 32'b1100);
        check("lu_c2_ls3", {28'd0, pw[2], iw[2], bub[2], busy[2]}, 32'b0011);
        tick();
        #1 check("lu_c3_ls3", {28'd0, pw[2], iw[2], bub[2], busy[2]}, 32'b0011);
        tick();
        #1 check("lu_c4_ls3", {28'd0, pw[2], iw[2], bub[2], busy[2]}, 32'b1100);

        // Flush in stall cycle 2.
        tick();
        hazard();
        tick();
        idex_memread = 1'b0; flush = 1'b1;
        #1 check("fl_c2_ls3", {28'd0, pw[2], iw[2], bub[2], busy[2]}, 32'b1101);
        tick();
        flush = 1'b0;
        #1 check("fl_c3_ls3", {28'd0, pw[2], iw[2], bub[2], busy[2]}, 32'b1100);

        // Reset in stall cycle 2.
        tick();
        hazard();
        tick();
        idex_memread = 1'b0; rst = 1'b0;
        idex_rs1 = 5'd5; exmem_rd = 5'd5; exmem_regwrite = 1'b1;
        #1 check("rst_c2_ls3", {28'd0, pw[2], iw[2], bub[2], busy[2]}, 32'b1101);
        check("rst_fwd_forced", 32'(fa[2]), 32'h0);
        tick();
        rst = 1'b1;
        quiet();
        #1 check("rst_c3_ls3", {28'd0, pw[2], iw[2], bub[2], busy[2]}, 32'b1100);

        // 20 back-to-back bubbles saturate a 4-bit counter.
        tick();
        hazard();
        repeat (20) tick();
        quiet();
`ifdef HAZ_STALL_CNT_EN
        #1 check("cnt_sat", 32'(sc[0]), 32'd15);
        repeat (3) tick();
        hazard();
        tick();
        quiet();
        #1 check("cnt_hold", 32'(sc[0]), 32'd15);
`endif

        // Random traffic with a narrow address range to force collisions.
        repeat (3000) begin
            tick();
            rst            = ($urandom_range(0, 63) != 0);
            flush          = ($urandom_range(0, 9) == 0);
            idex_memread   = ($urandom_range(0, 1) == 1);
            exmem_regwrite = ($urandom_range(0, 1) == 1);
            memwb_regwrite = ($urandom_range(0, 1) == 1);
            ifid_valid     = ($urandom_range(0, 7) != 0);
            idex_rs1       = AW'($urandom_range(0, 3));
            idex_rs2       = AW'($urandom_range(0, 3));
            idex_rd        = AW'($urandom_range(0, 3));
            exmem_rd       = AW'($urandom_range(0, 3));
            memwb_rd       = AW'($urandom_range(0, 3));
            ifid_rs1       = AW'($urandom_range(0, 3));
            ifid_rs2       = AW'($urandom_range(0, 3));
        end

        tick();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
